// File: rtl/bus_xfer_decoder_pkg.sv
// Shared definitions for the bus transfer decoder: FSM state encoding,
// select-code constants and the hold-cycle bounds.
// Optional feature macro: BUS_XFER_ERR_EN (reserved-code error pulse).
package bus_xfer_decoder_pkg;

  // Transfer FSM states; ST_ERR is only reachable when BUS_XFER_ERR_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_ERR   = 2'd3
  } xfer_state_e;

  // Code 31 selects nothing; code 30 is reserved.
  localparam logic [4:0] CODE_NONE = 5'd31;
  localparam logic [4:0] CODE_RSVD = 5'd30;

  // Legal range of the HOLD_CYCLES parameter and the hold counter width.
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;
  localparam int CNT_W    = 4;

  // Counter preload for a given hold length, clamped into the legal range
  // so an out-of-range parameter cannot wrap the 4-bit counter.
  function automatic logic [CNT_W-1:0] hold_load_f(input int hold);
    int h;
    h = hold;
    if (h < HOLD_MIN) begin
      h = HOLD_MIN;
    end else if (h > HOLD_MAX) begin
      h = HOLD_MAX;
    end else begin
      h = hold;
    end
    return CNT_W'(h - 1);
  endfunction

  // True when a select code is the reserved value.
  function automatic logic is_rsvd_f(input logic [4:0] code);
    return (code == CODE_RSVD);
  endfunction

endpackage

// File: rtl/bus_xfer_decoder_if.sv
// Request/bus-enable bundle between a transfer requester (master) and the
// bus transfer decoder (slave). The err signal exists only with BUS_XFER_ERR_EN.
interface bus_xfer_decoder_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  src_code;
  logic [4:0]  dst_code;
  logic [31:0] drive_en;
  logic [31:0] load_en;
  logic        busy;
  logic        done;
`ifdef BUS_XFER_ERR_EN
  logic        err;

  modport master (
    output req_valid, src_code, dst_code,
    input  req_ready, drive_en, load_en, busy, done, err
  );

  modport slave (
    input  req_valid, src_code, dst_code,
    output req_ready, drive_en, load_en, busy, done, err
  );
`else
  modport master (
    output req_valid, src_code, dst_code,
    input  req_ready, drive_en, load_en, busy, done
  );

  modport slave (
    input  req_valid, src_code, dst_code,
    output req_ready, drive_en, load_en, busy, done
  );
`endif

endinterface

// File: rtl/bus_code_dec.sv
// Combinational 5-to-32 select decoder. Code 0 maps to bit 7, codes 1..7
// map to bits 0..6, codes 8..29 map straight through, and 30/31 select nothing.
module bus_code_dec
  import bus_xfer_decoder_pkg::*;
(
  input  logic [4:0]  code,
  output logic [31:0] onehot
);

  // Map the select code onto its single enable bit.
  always_comb begin
    onehot = 32'd0;
    case (code)
      5'd0:                         onehot = 32'h0000_0080;
      5'd1, 5'd2, 5'd3, 5'd4,
      5'd5, 5'd6, 5'd7:             onehot = 32'd1 << (code - 5'd1);
      CODE_RSVD, CODE_NONE:         onehot = 32'd0;
      default:                      onehot = 32'd1 << code;
    endcase
  end

endmodule

// File: rtl/bus_xfer_decoder.sv
// Bus transfer decoder: accepts a source/destination request, drives the
// source onto the bus for HOLD_CYCLES cycles, then pulses the destination
// load enable while the source is still driving. All outputs are flops.
// Optional feature macro: BUS_XFER_ERR_EN -- reserved code 30 raises a
// one-cycle err pulse instead of starting a transfer.
module bus_xfer_decoder
  import bus_xfer_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  bus_xfer_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = hold_load_f(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  xfer_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       src_code_r;
  logic [4:0]       dst_code_r;

  logic             req_ready_r;
  logic             busy_r;
  logic             done_r;
  logic [31:0]      drive_en_r;
  logic [31:0]      load_en_r;
`ifdef BUS_XFER_ERR_EN
  logic             err_r;
  logic             rsvd_s;
`endif

  logic [4:0]       src_sel_s;
  logic [4:0]       dst_sel_s;
  logic [31:0]      src_oh_s;
  logic [31:0]      dst_oh_s;
  logic             accept_s;

  // Decode the live request codes while idle (so the first drive cycle is
  // registered from them) and the captured codes once a transfer is running.
  always_comb begin
    src_sel_s = (state_r == ST_IDLE) ? bus.src_code : src_code_r;
    dst_sel_s = (state_r == ST_IDLE) ? bus.dst_code : dst_code_r;
    accept_s  = bus.req_valid && req_ready_r;
`ifdef BUS_XFER_ERR_EN
    rsvd_s    = is_rsvd_f(bus.src_code) || is_rsvd_f(bus.dst_code);
`endif
  end

  bus_code_dec u_src_dec (
    .code   (src_sel_s),
    .onehot (src_oh_s)
  );

  bus_code_dec u_dst_dec (
    .code   (dst_sel_s),
    .onehot (dst_oh_s)
  );

  // Transfer FSM with all outputs registered from the next-state decisions.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      src_code_r  <= CODE_NONE;
      dst_code_r  <= CODE_NONE;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drive_en_r  <= 32'd0;
      load_en_r   <= 32'd0;
`ifdef BUS_XFER_ERR_EN
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r    <= 1'b0;
          load_en_r <= 32'd0;
          if (accept_s) begin
            src_code_r  <= bus.src_code;
            dst_code_r  <= bus.dst_code;
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
`ifdef BUS_XFER_ERR_EN
            if (rsvd_s) begin
              // Reserved code: flag it and spend one cycle with no enables.
              state_r    <= ST_ERR;
              cnt_r      <= CNT_ZERO;
              drive_en_r <= 32'd0;
              err_r      <= 1'b1;
            end else
`endif
            begin
              state_r    <= ST_DRIVE;
              cnt_r      <= HOLD_LOAD;
              drive_en_r <= src_oh_s;
            end
          end else begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            drive_en_r  <= 32'd0;
          end
        end

        ST_DRIVE: begin
          drive_en_r <= src_oh_s;
          if (cnt_r == CNT_ZERO) begin
            // Source has been on the bus long enough; load the destination.
            state_r   <= ST_LATCH;
            load_en_r <= dst_oh_s;
            done_r    <= 1'b1;
          end else begin
            cnt_r     <= cnt_r - CNT_ONE;
            load_en_r <= 32'd0;
            done_r    <= 1'b0;
          end
        end

        ST_LATCH: begin
          state_r     <= ST_IDLE;
          drive_en_r  <= 32'd0;
          load_en_r   <= 32'd0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
        end

        ST_ERR: begin
          state_r     <= ST_IDLE;
          drive_en_r  <= 32'd0;
          load_en_r   <= 32'd0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
`ifdef BUS_XFER_ERR_EN
          err_r       <= 1'b0;
`endif
        end

        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          drive_en_r  <= 32'd0;
          load_en_r   <= 32'd0;
          done_r      <= 1'b0;
          busy_r      <= 1'b0;
          req_ready_r <= 1'b1;
`ifdef BUS_XFER_ERR_EN
          err_r       <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.drive_en  = drive_en_r;
  assign bus.load_en   = load_en_r;
`ifdef BUS_XFER_ERR_EN
  assign bus.err       = err_r;
`endif

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// Directed bench for bus_xfer_decoder: two instances (HOLD_CYCLES 1 and 3)
// receive identical stimulus; table vectors plus hand sequences for
// continuous requests, mid-transfer clear and (optionally) reserved codes.
module tb_bus_xfer_decoder;

  typedef struct {
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [31:0] drv;
    logic [31:0] ld;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] src_code = 5'd0;
  logic [4:0] dst_code = 5'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_xfer_decoder_if if_h1 ();
  bus_xfer_decoder_if if_h3 ();

  assign if_h1.req_valid = req_valid;
  assign if_h1.src_code  = src_code;
  assign if_h1.dst_code  = dst_code;
  assign if_h3.req_valid = req_valid;
  assign if_h3.src_code  = src_code;
  assign if_h3.dst_code  = dst_code;

  bus_xfer_decoder #(.HOLD_CYCLES(1)) u_dut_h1 (.clk(clk), .clr(clr), .bus(if_h1));
  bus_xfer_decoder #(.HOLD_CYCLES(3)) u_dut_h3 (.clk(clk), .clr(clr), .bus(if_h3));

  // Spec decode table, used only by the hand sequences.
  function automatic logic [31:0] exp_oh(input logic [4:0] c);
    logic [31:0] one;
    one = 32'd1;
    if (c == 5'd0)       return 32'h0000_0080;
    else if (c <= 5'd7)  return one << (c - 5'd1);
    else if (c <= 5'd29) return one << c;
    else                 return 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Check one instance k cycles after the accept edge (k=0: idle before accept).
  task automatic chk_dut(input string tag, input int hold, input int k,
                         input logic [31:0] drv_oh, input logic [31:0] ld_oh);
    logic [31:0] a_drv, a_ld;
    logic a_done, a_busy, a_rdy, active;
    if (hold == 1) begin
      a_drv = if_h1.drive_en; a_ld = if_h1.load_en;
      a_done = if_h1.done; a_busy = if_h1.busy; a_rdy = if_h1.req_ready;
    end else begin
      a_drv = if_h3.drive_en; a_ld = if_h3.load_en;
      a_done = if_h3.done; a_busy = if_h3.busy; a_rdy = if_h3.req_ready;
    end
    active = (k >= 1) && (k <= hold + 1);
    chk($sformatf("%s h%0d k%0d drive_en", tag, hold, k), a_drv, active ? drv_oh : 32'd0);
    chk($sformatf("%s h%0d k%0d load_en", tag, hold, k), a_ld, (k == hold + 1) ? ld_oh : 32'd0);
    chk($sformatf("%s h%0d k%0d done", tag, hold, k), {31'd0, a_done}, {31'd0, (k == hold + 1)});
    chk($sformatf("%s h%0d k%0d busy", tag, hold, k), {31'd0, a_busy}, {31'd0, active});
    chk($sformatf("%s h%0d k%0d req_ready", tag, hold, k), {31'd0, a_rdy}, {31'd0, !active});
  endtask

  // One full transfer on both instances; codes are scrambled while busy.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    chk_dut(tag, 1, 0, v.drv, v.ld);
    chk_dut(tag, 3, 0, v.drv, v.ld);
    req_valid = 1'b1; src_code = v.src; dst_code = v.dst;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk_dut(tag, 1, k, v.drv, v.ld);
      chk_dut(tag, 3, k, v.drv, v.ld);
      req_valid = 1'b0;
      src_code = 5'd2 + 5'(k);
      dst_code = 5'd20 + 5'(k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [31:0] e_drv, e_ld;
    logic e_rdy;
    int ph, a;

    vecs.push_back('{5'd0,  5'd12, 32'h0000_0080, 32'h0000_1000});
    vecs.push_back('{5'd1,  5'd29, 32'h0000_0001, 32'h2000_0000});
    vecs.push_back('{5'd31, 5'd5,  32'h0000_0000, 32'h0000_0010});
    vecs.push_back('{5'd8,  5'd31, 32'h0000_0100, 32'h0000_0000});
    vecs.push_back('{5'd7,  5'd8,  32'h0000_0040, 32'h0000_0100});
    vecs.push_back('{5'd29, 5'd0,  32'h2000_0000, 32'h0000_0080});
    vecs.push_back('{5'd4,  5'd9,  32'h0000_0008, 32'h0000_0200});
`ifndef BUS_XFER_ERR_EN
    vecs.push_back('{5'd30, 5'd3,  32'h0000_0000, 32'h0000_0004});
    vecs.push_back('{5'd6,  5'd30, 32'h0000_0020, 32'h0000_0000});
`endif

    // Reset state.
    #2 clr = 1'b1;
    #3;
    chk_dut("reset", 1, 0, 32'd0, 32'd0);
    chk_dut("reset", 3, 0, 32'd0, 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // Table vectors.
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Continuous req_valid with changing codes: h1 takes codes at cycles 0,3,6.
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        ph = (c - 1) % 3;
        a  = (ph == 0) ? c - 1 : c - 2;
        e_drv = (ph == 2) ? 32'd0 : exp_oh(5'(8 + a));
        e_ld  = (ph == 1) ? exp_oh(5'(12 + a)) : 32'd0;
        e_rdy = (ph == 2);
        chk($sformatf("stream c%0d drive_en", c), if_h1.drive_en, e_drv);
        chk($sformatf("stream c%0d load_en", c), if_h1.load_en, e_ld);
        chk($sformatf("stream c%0d req_ready", c), {31'd0, if_h1.req_ready}, {31'd0, e_rdy});
      end
      req_valid = 1'b1; src_code = 5'(8 + c); dst_code = 5'(12 + c);
    end
    @(negedge clk);
    req_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // Clear during DRIVE aborts the transfer with no later load.
    @(negedge clk);
    req_valid = 1'b1; src_code = 5'd8; dst_code = 5'd4;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort pre drive_en", if_h3.drive_en, 32'h0000_0100);
    #2 clr = 1'b1;
    #1;
    chk("abort drive_en", if_h3.drive_en, 32'd0);
    chk("abort busy", {31'd0, if_h3.busy}, 32'd0);
    chk("abort h1 drive_en", if_h1.drive_en, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort post%0d load_en", k), if_h3.load_en, 32'd0);
      chk($sformatf("abort post%0d done", k), {31'd0, if_h3.done}, 32'd0);
      chk($sformatf("abort post%0d h1 load_en", k), if_h1.load_en, 32'd0);
    end
    v = '{5'd8, 5'd4, 32'h0000_0100, 32'h0000_0008};
    run_vec("after_abort", v);

`ifdef BUS_XFER_ERR_EN
    // Reserved code in source, then in destination.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      req_valid = 1'b1;
      src_code = (r == 0) ? 5'd30 : 5'd3;
      dst_code = (r == 0) ? 5'd4 : 5'd30;
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("rsvd%0d err h1", r), {31'd0, if_h1.err}, 32'd1);
      chk($sformatf("rsvd%0d err h3", r), {31'd0, if_h3.err}, 32'd1);
      chk($sformatf("rsvd%0d drive_en", r), if_h3.drive_en, 32'd0);
      chk($sformatf("rsvd%0d load_en", r), if_h3.load_en, 32'd0);
      chk($sformatf("rsvd%0d ready n1", r), {31'd0, if_h3.req_ready}, 32'd0);
      @(negedge clk);
      chk($sformatf("rsvd%0d err clear", r), {31'd0, if_h3.err}, 32'd0);
      chk($sformatf("rsvd%0d ready n2", r), {31'd0, if_h3.req_ready}, 32'd1);
      chk($sformatf("rsvd%0d ready n2 h1", r), {31'd0, if_h1.req_ready}, 32'd1);
      chk($sformatf("rsvd%0d load_en n2", r), if_h1.load_en, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_xfer_decoder.md
BUS_XFER_DECODER -- requirements
Module: bus_xfer_decoder

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1, number of cycles the source drives the bus before the destination loads (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  transfer request present.
REQ-005 SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port src_code  input  5  bus source select code.
REQ-007 SHALL have port dst_code  input  5  bus destination select code.
REQ-008 SHALL have port drive_en  output  32  one-hot bus drive enables.
REQ-009 SHALL have port load_en  output  32  one-hot register load enables.
REQ-010 SHALL have port busy  output  1  transfer in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse in the load cycle.
REQ-012 SHALL have port err  output  1  reserved-code pulse (only with BUS_XFER_ERR_EN).

Function
REQ-013 SHALL decode a 5-bit code to a 32-bit one-hot vector: 0->bit 7; 1..7->bit (code-1); 8..29->bit code; 31->all zero (no select); 30 reserved.
REQ-014 SHALL implement FSM states IDLE, DRIVE, LATCH.
REQ-015 In IDLE: req_ready=1, busy=0, drive_en=load_en=0; on req_valid&&req_ready capture src_code/dst_code, load hold counter with HOLD_CYCLES-1, go DRIVE.
REQ-016 In DRIVE: drive_en=onehot(src), load_en=0, busy=1, req_ready=0; counter decrements each cycle; at counter 0 go LATCH.
REQ-017 In LATCH: drive_en=onehot(src) still held, load_en=onehot(dst) for exactly one cycle, done=1, busy=1; then IDLE.
REQ-018 Latency: request accepted at edge N -> drive_en from N+1 through N+HOLD_CYCLES, load_en/done at N+HOLD_CYCLES+1, req_ready high at N+HOLD_CYCLES+2.
REQ-019 No back-to-back acceptance: req_ready SHALL be 0 in DRIVE and LATCH; input changes there are ignored.
REQ-020 src_code 31: drive_en stays zero throughout; transfer still completes with load_en per dst.
REQ-021 dst_code 31: load_en stays zero; done still pulses.
REQ-022 All outputs SHALL come directly from flops (glitch-free), registered from next-state logic.
REQ-023 At most one bit of drive_en and of load_en SHALL ever be set.

Reset
REQ-024 clr high SHALL immediately force IDLE, counter 0, captured codes 31, drive_en=load_en=0, done=err=busy=0, req_ready=1 after release.
REQ-025 clr asserted mid-DRIVE or mid-LATCH SHALL abort the transfer with no load_en pulse after reset.

Configuration
REQ-026 With macro BUS_XFER_ERR_EN defined: code 30 in src or dst SHALL be accepted, pulse err for one cycle at N+1, assert no enables, return to IDLE (ready at N+2).
REQ-027 Without BUS_XFER_ERR_EN: err port absent; code 30 treated identically to 31.

Structure
REQ-028 Shared package SHALL hold the state enum, code constants (CODE_NONE=31, CODE_RSVD=30), and HOLD_CYCLES bound.
REQ-029 One sub-module bus_code_dec (combinational 5-to-32 decode per REQ-013) SHALL be instantiated twice (source, destination).

Verification
REQ-030 HOLD_CYCLES=1, src=0, dst=12 -> drive_en=0x00000080 one cycle, then LATCH: drive_en=0x00000080, load_en=0x00001000, done=1.
REQ-031 HOLD_CYCLES=3, src=1, dst=29 -> drive_en=0x00000001 for 4 cycles, load_en=0x20000000 in the 4th, ready after.
REQ-032 req_valid held high continuously with changing codes -> only codes present at ready cycles taken; no overlap.
REQ-033 clr pulsed during DRIVE (src=8) -> drive_en=0 immediately, no load_en, next request completes normally.
REQ-034 src=31, dst=5 -> drive_en stays 0, load_en=0x00000010, done=1.
REQ-035 BUS_XFER_ERR_EN defined, src=30 -> err=1 one cycle, drive_en=load_en=0, ready two cycles after accept.
